ti_simon_share_loader: RTL and testbench

Upstream feeder for the bit-serial 2-share Simon-128/128 core (`TI_Simon_Core`). It accepts a parallel 128-bit key and a 128-bit plaintext through a ready/start handshake and splits each bit into two shares. It then streams the shares LSB-first on the core's `data_ina`/`data_inb`/`data_rdy` load interface: 128 key cycles, then 128 plaintext cycles. Finally it holds the core in run mode until the core's `Done` pulses.

---
 rtl/ti_simon_pkg.sv | 32 +++
 rtl/ti_simon_share_split.sv | 50 +++++
 rtl/ti_simon_share_loader.sv | 118 +++++++++++
 tb/tb_ti_simon_share_loader.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ti_simon_pkg.sv
// Shared constants, FSM state type and load-phase codes for the Simon share loader.
package ti_simon_pkg;

    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_PT   = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [1:0] RDY_IDLE = 2'b00;
    localparam logic [1:0] RDY_KEY  = 2'b10;
    localparam logic [1:0] RDY_PT   = 2'b01;
    localparam logic [1:0] RDY_RUN  = 2'b11;

    function automatic logic [1:0] rdy_code(input state_t s);
        logic [1:0] code;
        code = RDY_IDLE;
        case (s)
            ST_IDLE: code = RDY_IDLE;
            ST_KEY:  code = RDY_KEY;
            ST_PT:   code = RDY_PT;
            ST_RUN:  code = RDY_RUN;
            default: code = RDY_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ti_simon_share_split.sv
// Registers one serial bit as two XOR shares; masking enabled by SIMON_LOADER_MASK_EN,
// otherwise share A carries the plain bit and share B is zero.
module ti_simon_share_split (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic bit_i,
    input  logic rnd_i,
    output logic a_o,
    output logic b_o
);

    logic a_d, a_q;
    logic b_d, b_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        a_d = 1'b0;
        b_d = 1'b0;
        if (en_i) begin
`ifdef SIMON_LOADER_MASK_EN
            a_d = bit_i ^ rnd_i;
            b_d = rnd_i;
`else
            a_d = bit_i;
            b_d = 1'b0;
`endif
        end
    end

`ifndef SIMON_LOADER_MASK_EN
    logic unused_rnd;
    assign unused_rnd = rnd_i;
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    assign a_o = a_q;
    assign b_o = b_q;

endmodule

// File: rtl/ti_simon_share_loader.sv
// Loads key then plaintext bit-serially (LSB first) into the 2-share Simon core, then waits for Done.
// Share masking of the serial stream is selected by SIMON_LOADER_MASK_EN.
module ti_simon_share_loader #(
    parameter int BLOCK_W = ti_simon_pkg::BLOCK_W,
    parameter int CNT_W   = ti_simon_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] key_in,
    input  logic [BLOCK_W-1:0] pt_in,
    input  logic               rnd_in,
    input  logic               done_in,
    output logic               ready,
    output logic               data_ina,
    output logic               data_inb,
    output logic [1:0]         data_rdy
);

    import ti_simon_pkg::*;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] key_sr_q, key_sr_d;
    logic [BLOCK_W-1:0] pt_sr_q, pt_sr_d;
    logic               ready_q, ready_d;
    logic [1:0]         data_rdy_q, data_rdy_d;
    logic               split_en;
    logic               split_bit;

    // state/cnt always describe the bit currently on the outputs; split_bit is the next one.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        key_sr_d  = key_sr_q;
        pt_sr_d   = pt_sr_q;
        split_en  = 1'b0;
        split_bit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_KEY;
                    cnt_d     = '0;
                    key_sr_d  = key_in;
                    pt_sr_d   = pt_in;
                    split_en  = 1'b1;
                    split_bit = key_in[0];
                end
            end
            ST_KEY: begin
                split_en = 1'b1;
                key_sr_d = key_sr_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_PT;
                    cnt_d     = '0;
                    split_bit = pt_sr_q[0];
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    split_bit = key_sr_q[1];
                end
            end
            ST_PT: begin
                pt_sr_d = pt_sr_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    split_en  = 1'b1;
                    split_bit = pt_sr_q[1];
                end
            end
            ST_RUN: begin
                if (done_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d    = (state_d == ST_IDLE);
        data_rdy_d = rdy_code(state_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            // NOTE: the shift registers are reset too, so no stale key material survives a reset.
            key_sr_q   <= '0;
            pt_sr_q    <= '0;
            ready_q    <= 1'b1;
            data_rdy_q <= RDY_IDLE;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_sr_q   <= key_sr_d;
            pt_sr_q    <= pt_sr_d;
            ready_q    <= ready_d;
            data_rdy_q <= data_rdy_d;
        end
    end

    ti_simon_share_split u_split (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (split_en),
        .bit_i (split_bit),
        .rnd_i (rnd_in),
        .a_o   (data_ina),
        .b_o   (data_inb)
    );

    assign ready    = ready_q;
    assign data_rdy = data_rdy_q;

endmodule

// File: tb/tb_ti_simon_share_loader.sv
// Directed self-checking bench for ti_simon_share_loader (works with SIMON_LOADER_MASK_EN on or off).
module tb_ti_simon_share_loader;

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] PT  = 128'h63736564207372656c6c657661727420;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] pt_in;
    logic         rnd_in;
    logic         done_in;
    logic         ready;
    logic         data_ina;
    logic         data_inb;
    logic [1:0]   data_rdy;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           masked_cnt = 0;
    logic [255:0] stream;
    logic [15:0]  lfsr;
    logic         rnd_sent;

    always #5 clk = ~clk;

    ti_simon_share_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .pt_in    (pt_in),
        .rnd_in   (rnd_in),
        .done_in  (done_in),
        .ready    (ready),
        .data_ina (data_ina),
        .data_inb (data_inb),
        .data_rdy (data_rdy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive a fresh random bit, advance one clock, sample 1 time unit after the edge.
    task automatic step();
        rnd_in   = lfsr[0];
        rnd_sent = lfsr[0];
        lfsr     = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input int i);
        logic [1:0] exp_rdy;
        logic       exp_b;
        exp_rdy = (i < 128) ? 2'b10 : 2'b01;
        exp_b   = stream[i];
        check($sformatf("ready_bit%0d", i), ready, 1'b0);
        check($sformatf("rdy_bit%0d", i), data_rdy, exp_rdy);
        check($sformatf("xor_bit%0d", i), data_ina ^ data_inb, exp_b);
        if (data_ina != exp_b) masked_cnt++;
`ifdef SIMON_LOADER_MASK_EN
        check($sformatf("inb_rnd_bit%0d", i), data_inb, rnd_sent);
`else
        check($sformatf("inb_zero_bit%0d", i), data_inb, 1'b0);
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, ready, 1'b1);
        check({tag, "_rdy"}, data_rdy, 2'b00);
        check({tag, "_ina"}, data_ina, 1'b0);
        check({tag, "_inb"}, data_inb, 1'b0);
    endtask

    task automatic check_run(input string tag);
        check({tag, "_ready"}, ready, 1'b0);
        check({tag, "_rdy"}, data_rdy, 2'b11);
        check({tag, "_ina"}, data_ina, 1'b0);
        check({tag, "_inb"}, data_inb, 1'b0);
    endtask

    initial begin
        stream  = {PT, KEY};
        lfsr    = 16'hace1;
        rst_n   = 1'b0;
        start   = 1'b0;
        done_in = 1'b0;
        rnd_in  = 1'b0;
        key_in  = KEY;
        pt_in   = PT;

        step();
        step();
        check_idle("reset");
        rst_n = 1'b1;
        step();
        check_idle("idle");

        // Load 1: stray start pulses, input corruption and an early done must all be ignored.
        start = 1'b1;
        step();
        start = 1'b0;
        check_bit(0);
        for (int i = 1; i < 256; i++) begin
            start   = (i == 10 || i == 150);
            done_in = (i == 20);
            if (i == 10) begin
                key_in = ~KEY;
                pt_in  = ~PT;
            end
            step();
            start   = 1'b0;
            done_in = 1'b0;
            check_bit(i);
        end
        for (int k = 0; k < 50; k++) begin
            start = ((256 + k) == 300);
            step();
            start = 1'b0;
            check_run("run1");
        end
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check_idle("done1");
`ifdef SIMON_LOADER_MASK_EN
        check("mask_ratio", (masked_cnt * 10 >= 256 * 4) ? 1 : 0, 1);
`else
        check("plain_ina", masked_cnt, 0);
`endif

        // Load 2: synchronous reset at plaintext bit 50.
        key_in = KEY;
        pt_in  = PT;
        start  = 1'b1;
        step();
        start  = 1'b0;
        check_bit(0);
        for (int i = 1; i <= 178; i++) begin
            step();
            check_bit(i);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("midreset");
        step();
        check_idle("post_reset");

        // Load 3: fresh load from key bit 0, done 40 cycles into RUN.
        start = 1'b1;
        step();
        start = 1'b0;
        check_bit(0);
        for (int i = 1; i < 256; i++) begin
            step();
            check_bit(i);
        end
        for (int k = 0; k < 40; k++) begin
            step();
            check_run("run3");
        end

        // Back-to-back: start held high across done restarts the load right after ready rises.
        done_in = 1'b1;
        start   = 1'b1;
        step();
        done_in = 1'b0;
        check_idle("done3");
        step();
        check_bit(0);
        for (int i = 1; i < 256; i++) begin
            step();
            check_bit(i);
        end
        step();
        check_run("run4");
        start   = 1'b0;
        done_in = 1'b1;
        step();
        done_in = 1'b0;
        check_idle("done4");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
